// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches the word at pc_curr from IMEM
// over a req/rvalid handshake, holds it for the decoder until the core steps,
// then commits pc_next verbatim. Misaligned targets halt the stage; only reset
// leaves HALT. Retired instructions are counted in instret (wraps silently).
//
// Handshake: imem_req is high in every REQ cycle (reset gates it low) and
// imem_addr is always pc_curr. A response is accepted in any REQ cycle with
// imem_rvalid=1, and imem_rdata is sampled on that same edge. rvalid seen
// outside REQ is dropped.
//
// Optional feature: define IFETCH_TIMEOUT_EN to bound the REQ wait to
// TIMEOUT_CYCLES cycles; on expiry fetch_err and fetch_timeout are set and
// the stage halts. Without the macro REQ waits forever and fetch_timeout is 0.
//
// Debug: state exposes the FSM (0=REQ, 1=EXEC, 2=HALT).
module ifetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_next,
    input  logic        step,
    output logic [31:0] pc_curr,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        fetch_err,
    output logic        fetch_timeout,
    output logic [31:0] instret,
    output logic [1:0]  state
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // The timeout needs at least one counted cycle before the final one.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("ifetch_unit: TIMEOUT_CYCLES must be >= 2");
    end

    logic step_ok;   // commit to an aligned target: go fetch again
    logic step_bad;  // commit to a misaligned target: halt

    assign step_ok  = (state == ST_EXEC) && step && (pc_next[1:0] == 2'b00);
    assign step_bad = (state == ST_EXEC) && step && (pc_next[1:0] != 2'b00);

    // Reset gates the request so it is low for as long as reset is held.
    assign imem_req  = (state == ST_REQ) && !reset;
    assign imem_addr = pc_curr;

`ifdef IFETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] to_cnt;
    logic          to_fire;

    // rvalid in the final cycle wins over the timeout.
    assign to_fire = (state == ST_REQ) && !imem_rvalid && (to_cnt == TO_LAST);

    // Count silent REQ cycles; cleared whenever REQ is (re)entered.
    always_ff @(posedge clk) begin
        if (reset || step_ok) begin
            to_cnt <= '0;
        end else if ((state == ST_REQ) && !imem_rvalid && !to_fire) begin
            to_cnt <= to_cnt + CW'(1);
        end
    end

    // Sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_timeout <= 1'b0;
        end else if (to_fire) begin
            fetch_timeout <= 1'b1;
        end
    end
`else
    logic to_fire;

    assign to_fire       = 1'b0;
    assign fetch_timeout = 1'b0;
`endif

    // Fetch FSM, PC, instruction register, error flag and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_REQ;
            pc_curr     <= RESET_PC;
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            instret     <= 32'd0;
        end else begin
            case (state)
                ST_REQ: begin
                    if (imem_rvalid) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= ST_EXEC;
                    end else if (to_fire) begin
                        fetch_err <= 1'b1;
                        state     <= ST_HALT;
                    end
                end
                ST_EXEC: begin
                    if (step_ok || step_bad) begin
                        pc_curr     <= pc_next;
                        instr       <= NOP_INSTR;
                        instr_valid <= 1'b0;
                        instret     <= instret + 32'd1;
                    end
                    if (step_ok) begin
                        state <= ST_REQ;
                    end else if (step_bad) begin
                        fetch_err <= 1'b1;
                        state     <= ST_HALT;
                    end
                end
                default: begin
                    state <= ST_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus randomized fetch/step
// traffic, all checked against a transaction-level model of the fetch stage.
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int          TO       = 16;
    localparam logic [1:0]  S_HALT   = 2'd2;

    logic        clk;
    logic        reset;
    logic [31:0] pc_next;
    logic        step;
    logic [31:0] pc_curr;
    logic [31:0] instr;
    logic        instr_valid;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        fetch_err;
    logic        fetch_timeout;
    logic [31:0] instret;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what the stage should show, in terms of fetches and steps.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_instret;
    logic        m_valid;
    logic        m_waiting;   // a fetch is outstanding
    logic        m_halted;
    logic        m_err;
    logic        m_to;
    int          m_silent;    // silent cycles of the current fetch

    ifetch_unit #(
        .RESET_PC(RESET_PC),
        .NOP_INSTR(NOP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pc_next(pc_next),
        .step(step),
        .pc_curr(pc_curr),
        .instr(instr),
        .instr_valid(instr_valid),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .fetch_err(fetch_err),
        .fetch_timeout(fetch_timeout),
        .instret(instret),
        .state(state)
    );

    // Clock and cycle helper.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = RESET_PC;
        m_instr   = NOP;
        m_instret = 32'd0;
        m_valid   = 1'b0;
        m_waiting = 1'b1;
        m_halted  = 1'b0;
        m_err     = 1'b0;
        m_to      = 1'b0;
        m_silent  = 0;
    endtask

    // One clock of the stage's rules, applied to the inputs now being driven.
    task automatic model_clock();
        if (m_halted) begin
            // frozen until reset
        end else if (m_waiting) begin
            if (imem_rvalid) begin
                m_instr   = imem_rdata;
                m_valid   = 1'b1;
                m_waiting = 1'b0;
            end else begin
                m_silent++;
`ifdef IFETCH_TIMEOUT_EN
                if (m_silent == TO) begin
                    m_err    = 1'b1;
                    m_to     = 1'b1;
                    m_halted = 1'b1;
                end
`endif
            end
        end else if (step) begin
            m_pc      = pc_next;
            m_valid   = 1'b0;
            m_instret = m_instret + 32'd1;
            if (pc_next[1:0] == 2'b00) begin
                m_waiting = 1'b1;
                m_silent  = 0;
            end else begin
                m_err    = 1'b1;
                m_halted = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, pc_curr, m_pc);
        check({tag, ".addr"}, imem_addr, m_pc);
        check({tag, ".req"}, {31'd0, imem_req}, {31'd0, m_waiting && !m_halted});
        check({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, m_valid});
        check({tag, ".instret"}, instret, m_instret);
        check({tag, ".err"}, {31'd0, fetch_err}, {31'd0, m_err});
        check({tag, ".timeout"}, {31'd0, fetch_timeout}, {31'd0, m_to});
        if (m_valid) check({tag, ".instr"}, instr, m_instr);
        if (m_halted) check({tag, ".state"}, {30'd0, state}, {30'd0, S_HALT});
    endtask

    // Drive one cycle of inputs, advance the model, clock, compare.
    task automatic cyc(input string tag, input logic rv, input logic [31:0] rd,
                       input logic st, input logic [31:0] pn);
        imem_rvalid = rv;
        imem_rdata  = rd;
        step        = st;
        pc_next     = pn;
        model_clock();
        tick();
        check_all(tag);
    endtask

    task automatic do_reset(input int n);
        reset       = 1'b1;
        imem_rvalid = 1'b0;
        step        = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            model_reset();
            check("rst.req", {31'd0, imem_req}, 32'd0);
            check("rst.instr", instr, NOP);
            check("rst.valid", {31'd0, instr_valid}, 32'd0);
        end
        reset = 1'b0;
        #1;
        check_all("rst");
    endtask

    // Stimulus.
    initial begin
        logic [31:0] a;
        int          d;
        reset       = 1'b1;
        pc_next     = 32'd0;
        step        = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        model_reset();

        // Reset, then a fetch answered after one silent cycle.
        do_reset(2);
        check("t1.addr0", imem_addr, 32'd0);
        cyc("t1.wait", 1'b0, 32'hDEAD_BEEF, 1'b0, 32'd0);
        cyc("t1.resp", 1'b1, 32'h0050_0093, 1'b0, 32'd0);
        check("t1.instr", instr, 32'h0050_0093);
        check("t1.valid", {31'd0, instr_valid}, 32'd1);

        // Step to PC 4: new fetch requested the following cycle.
        cyc("t2.step", 1'b0, 32'd0, 1'b1, 32'h0000_0004);
        check("t2.pc", pc_curr, 32'h4);
        check("t2.instret", instret, 32'd1);
        check("t2.req", {31'd0, imem_req}, 32'd1);

        // step held through a 5-cycle IMEM delay is ignored.
        for (int i = 0; i < 5; i++) begin
            cyc("t3.wait", 1'b0, $urandom, 1'b1, 32'h0000_0040);
            check("t3.pc", pc_curr, 32'h4);
            check("t3.instret", instret, 32'd1);
        end
        cyc("t3.resp", 1'b1, 32'h0011_0113, 1'b1, 32'h0000_0040);
        check("t3.pc_hold", pc_curr, 32'h4);

        // Misaligned target halts; outputs frozen for 20 cycles.
        cyc("t4.bad", 1'b0, 32'd0, 1'b1, 32'h0000_0102);
        check("t4.err", {31'd0, fetch_err}, 32'd1);
        check("t4.pc", pc_curr, 32'h102);
        for (int i = 0; i < 20; i++) begin
            cyc("t4.halt", 1'($urandom), $urandom, 1'($urandom), $urandom & 32'hFFFF_FFFC);
            check("t4.req0", {31'd0, imem_req}, 32'd0);
        end
        do_reset(1);
        check("t4.pc_rst", pc_curr, RESET_PC);

        // Randomized fetch/execute traffic.
        for (int t = 0; t < 30; t++) begin
            d = $urandom_range(0, 6);
            for (int i = 0; i < d; i++)
                cyc("rnd.wait", 1'b0, $urandom, 1'($urandom), $urandom);
            cyc("rnd.resp", 1'b1, $urandom, 1'($urandom), $urandom);
            d = $urandom_range(0, 3);
            for (int i = 0; i < d; i++)
                cyc("rnd.exec", 1'($urandom), $urandom, 1'b0, $urandom);
            a = $urandom & 32'hFFFF_FFFC;
            cyc("rnd.step", 1'($urandom), $urandom, 1'b1, a);
        end

        // Timeout: silent IMEM, then rvalid arriving in the last allowed cycle.
        do_reset(1);
`ifdef IFETCH_TIMEOUT_EN
        for (int i = 0; i < TO; i++)
            cyc("t5.silent", 1'b0, $urandom, 1'($urandom), $urandom);
        check("t5.to", {31'd0, fetch_timeout}, 32'd1);
        check("t5.err", {31'd0, fetch_err}, 32'd1);
        check("t5.valid", {31'd0, instr_valid}, 32'd0);
        do_reset(1);
        for (int i = 0; i < TO - 1; i++)
            cyc("t5.late", 1'b0, $urandom, 1'b0, 32'd0);
        cyc("t5.last", 1'b1, 32'h1234_5678, 1'b0, 32'd0);
        check("t5.no_to", {31'd0, fetch_timeout}, 32'd0);
        check("t5.instr", instr, 32'h1234_5678);
`else
        for (int i = 0; i < 40; i++)
            cyc("t5.wait", 1'b0, $urandom, 1'($urandom), $urandom);
        check("t5.no_to", {31'd0, fetch_timeout}, 32'd0);
        check("t5.req", {31'd0, imem_req}, 32'd1);
        cyc("t5.resp", 1'b1, 32'h1234_5678, 1'b0, 32'd0);
`endif

        // instret wrap: preload all-ones, then retire one instruction.
        do_reset(1);
        cyc("t6.resp", 1'b1, 32'h0000_0013, 1'b0, 32'd0);
        force dut.instret = 32'hFFFF_FFFF;
        #1;
        release dut.instret;
        #1;
        m_instret = 32'hFFFF_FFFF;
        check("t6.preload", instret, 32'hFFFF_FFFF);
        cyc("t6.wrap", 1'b0, 32'd0, 1'b1, 32'h0000_0200);
        check("t6.instret0", instret, 32'd0);

        // Reset in the middle of a REQ handshake.
        cyc("t6.wait", 1'b0, 32'd0, 1'b0, 32'd0);
        reset       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        tick();
        model_reset();
        check("t6.req_drop", {31'd0, imem_req}, 32'd0);
        check("t6.nop", instr, NOP);
        check("t6.valid0", {31'd0, instr_valid}, 32'd0);
        check("t6.pc", pc_curr, RESET_PC);
        reset       = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        check_all("t6.after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
